// File: rtl/map_table_write_ctrl.sv
// map_table_write_ctrl
//   Drives the single write port of the rename map table. After reset and on
//   every misprediction recovery it sweeps entries 1..31 with the identity
//   mapping; afterwards it arbitrates the port between dispatch renames and a
//   small FIFO of buffered commit writes. All mt_* outputs are registered on
//   the rising edge so they are stable for the table's falling-edge write.
//
// Ports
//   clock, reset                 clock / async active-high reset
//   dispatch_valid/reg/tag       rename write request (tag zero-extended)
//   dispatch_ready               dispatch accepted when valid & ready
//   commit_valid/reg/data        commit write request, buffered in FIFO
//   commit_ready                 commit FIFO can accept
//   recover                      one-cycle pulse: flush and re-sweep
//   mt_write_reg/data, mt_reg_write   map table write port
//   init_done                    high in RUN
//
// State | meaning
// ------+----------------------------------------------------------
// SWEEP | identity init, one entry per cycle, sweep_cnt = 1..31
// RUN   | normal arbitration between dispatch and commit FIFO
module map_table_write_ctrl #(
    parameter int TAG_W    = 6,
    parameter int CQ_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dispatch_valid,
    input  logic [4:0]       dispatch_reg,
    input  logic [TAG_W-1:0] dispatch_tag,
    output logic             dispatch_ready,
    input  logic             commit_valid,
    input  logic [4:0]       commit_reg,
    input  logic [31:0]      commit_data,
    output logic             commit_ready,
    input  logic             recover,
    output logic [4:0]       mt_write_reg,
    output logic [31:0]      mt_write_data,
    output logic             mt_reg_write,
    output logic             init_done
);

    localparam int PW = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(CQ_DEPTH);

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [4:0]     sweep_cnt, sweep_cnt_nxt;

    logic [4:0]     q_reg  [CQ_DEPTH];
    logic [31:0]    q_data [CQ_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic           q_full, q_empty;
    logic           push, pop, flush;

    logic           we_nxt;
    logic [4:0]     reg_nxt;
    logic [31:0]    data_nxt;

    assign q_full  = (count == FULL_CNT);
    assign q_empty = (count == '0);

    // Readies come from registered state; recover only forces them low.
    assign init_done      = (state == RUN);
    assign dispatch_ready = (state == RUN) && !q_full && !recover;
    assign commit_ready   = (state == RUN) && !q_full && !recover;

    assign push = commit_valid && commit_ready;

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        pop           = 1'b0;
        flush         = 1'b0;
        we_nxt        = 1'b0;
        reg_nxt       = 5'd0;
        data_nxt      = 32'd0;

        case (state)
            RUN: begin
                if (recover) begin
                    state_nxt     = SWEEP;
                    sweep_cnt_nxt = 5'd1;
                    flush         = 1'b1;
                end else if (q_full || (!dispatch_valid && !q_empty)) begin
                    // A full queue takes the port so commits cannot starve.
                    pop      = 1'b1;
                    reg_nxt  = q_reg[rd_ptr];
                    data_nxt = q_data[rd_ptr];
                    we_nxt   = (q_reg[rd_ptr] != 5'd0);
                end else if (dispatch_valid) begin
                    reg_nxt  = dispatch_reg;
                    data_nxt = 32'(dispatch_tag);
                    we_nxt   = (dispatch_reg != 5'd0);
                end
            end
            default: begin
                // SWEEP, and any corrupted encoding, behaves as the sweep.
                state_nxt = SWEEP;
                if (recover) begin
                    sweep_cnt_nxt = 5'd1;
                    flush         = 1'b1;
                end else begin
                    we_nxt   = 1'b1;
                    reg_nxt  = sweep_cnt;
                    data_nxt = {27'd0, sweep_cnt};
                    if (sweep_cnt == 5'd31) begin
                        state_nxt     = RUN;
                        sweep_cnt_nxt = 5'd1;
                    end else begin
                        sweep_cnt_nxt = sweep_cnt + 5'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + 1'b1;
            if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SWEEP;
            sweep_cnt     <= 5'd1;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            mt_reg_write  <= 1'b0;
            mt_write_reg  <= 5'd0;
            mt_write_data <= 32'd0;
        end else begin
            state         <= state_nxt;
            sweep_cnt     <= sweep_cnt_nxt;
            rd_ptr        <= rd_ptr_nxt;
            wr_ptr        <= wr_ptr_nxt;
            count         <= count_nxt;
            mt_reg_write  <= we_nxt;
            mt_write_reg  <= reg_nxt;
            mt_write_data <= data_nxt;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push) begin
            q_reg[wr_ptr]  <= commit_reg;
            q_data[wr_ptr] <= commit_data;
        end
    end

endmodule

// File: tb/tb_map_table_write_ctrl.sv
module tb_map_table_write_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic [4:0]  dispatch_reg;
    logic [5:0]  dispatch_tag;
    logic        dispatch_ready;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] commit_data;
    logic        commit_ready;
    logic        recover;
    logic [4:0]  mt_write_reg;
    logic [31:0] mt_write_data;
    logic        mt_reg_write;
    logic        init_done;

    int compared   = 0;
    int mismatched = 0;

    map_table_write_ctrl #(.TAG_W(6), .CQ_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_reg   (dispatch_reg),
        .dispatch_tag   (dispatch_tag),
        .dispatch_ready (dispatch_ready),
        .commit_valid   (commit_valid),
        .commit_reg     (commit_reg),
        .commit_data    (commit_data),
        .commit_ready   (commit_ready),
        .recover        (recover),
        .mt_write_reg   (mt_write_reg),
        .mt_write_data  (mt_write_data),
        .mt_reg_write   (mt_reg_write),
        .init_done      (init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        dv;
        logic [4:0]  dreg;
        logic [5:0]  dtag;
        logic        cv;
        logic [4:0]  creg;
        logic [31:0] cdata;
        logic        rec;
        logic        e_dr;
        logic        e_cr;
        logic        e_init;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[17];

    function automatic vec_t mk(logic dv, logic [4:0] dreg, logic [5:0] dtag,
                                logic cv, logic [4:0] creg, logic [31:0] cdata,
                                logic rec, logic e_dr, logic e_cr, logic e_init,
                                logic e_we, logic [4:0] e_reg, logic [31:0] e_data);
        vec_t v;
        v.dv = dv; v.dreg = dreg; v.dtag = dtag;
        v.cv = cv; v.creg = creg; v.cdata = cdata; v.rec = rec;
        v.e_dr = e_dr; v.e_cr = e_cr; v.e_init = e_init;
        v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, check readies, queue the expected write,
    // cross one rising edge and compare the registered write port.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        dispatch_valid = v.dv;
        dispatch_reg   = v.dreg;
        dispatch_tag   = v.dtag;
        commit_valid   = v.cv;
        commit_reg     = v.creg;
        commit_data    = v.cdata;
        recover        = v.rec;
        #1;
        chk({tag, ".dispatch_ready"}, 32'(dispatch_ready), 32'(v.e_dr));
        chk({tag, ".commit_ready"},   32'(commit_ready),   32'(v.e_cr));
        chk({tag, ".init_done"},      32'(init_done),      32'(v.e_init));
        e.we = v.e_we; e.wreg = v.e_reg; e.wdata = v.e_data;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        got = sb.pop_front();
        chk({tag, ".mt_reg_write"}, 32'(mt_reg_write), 32'(got.we));
        if (got.we) begin
            chk({tag, ".mt_write_reg"},  32'(mt_write_reg), 32'(got.wreg));
            chk({tag, ".mt_write_data"}, mt_write_data,     got.wdata);
        end
    endtask

    task automatic run_sweep(input int n);
        for (int i = 1; i <= n; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 32'(i)), $sformatf("sweep%0d", i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           dv dreg dtag   cv creg cdata       rec dr cr in we reg data
        tbl[0]  = mk(0, 0, 6'h00,   0, 0,  32'h0,        0, 1, 1, 1, 0, 0, 32'h0);
        tbl[1]  = mk(1, 5, 6'h2A,   0, 0,  32'h0,        0, 1, 1, 1, 1, 5, 32'h2A);
        tbl[2]  = mk(1, 3, 6'h3F,   1, 7,  32'h11,       0, 1, 1, 1, 1, 3, 32'h3F);
        tbl[3]  = mk(1, 4, 6'h01,   1, 8,  32'h22,       0, 1, 1, 1, 1, 4, 32'h01);
        tbl[4]  = mk(1, 6, 6'h02,   0, 0,  32'h0,        0, 0, 0, 1, 1, 7, 32'h11);
        tbl[5]  = mk(1, 6, 6'h02,   0, 0,  32'h0,        0, 1, 1, 1, 1, 6, 32'h02);
        tbl[6]  = mk(0, 0, 6'h00,   0, 0,  32'h0,        0, 1, 1, 1, 1, 8, 32'h22);
        tbl[7]  = mk(0, 0, 6'h00,   0, 0,  32'h0,        0, 1, 1, 1, 0, 0, 32'h0);
        tbl[8]  = mk(1, 0, 6'h15,   0, 0,  32'h0,        0, 1, 1, 1, 0, 0, 32'h0);
        tbl[9]  = mk(0, 0, 6'h00,   1, 0,  32'h99,       0, 1, 1, 1, 0, 0, 32'h0);
        tbl[10] = mk(0, 0, 6'h00,   1, 9,  32'h77,       0, 1, 1, 1, 0, 0, 32'h0);
        tbl[11] = mk(0, 0, 6'h00,   0, 0,  32'h0,        0, 1, 1, 1, 1, 9, 32'h77);
        tbl[12] = mk(1, 1, 6'h01,   1, 10, 32'h0A,       0, 1, 1, 1, 1, 1, 32'h01);
        tbl[13] = mk(1, 2, 6'h02,   1, 11, 32'h0B,       0, 1, 1, 1, 1, 2, 32'h02);
        tbl[14] = mk(1, 3, 6'h03,   1, 12, 32'h0C,       1, 0, 0, 1, 0, 0, 32'h0);
        tbl[15] = mk(0, 0, 6'h00,   0, 0,  32'h0,        0, 1, 1, 1, 0, 0, 32'h0);
        tbl[16] = mk(1, 17, 6'h33,  0, 0,  32'h0,        0, 1, 1, 1, 1, 17, 32'h33);

        reset = 1'b1;
        dispatch_valid = 0; dispatch_reg = 0; dispatch_tag = 0;
        commit_valid = 0; commit_reg = 0; commit_data = 0; recover = 0;
        repeat (2) @(negedge clock);
        chk("reset.mt_reg_write",   32'(mt_reg_write),   32'd0);
        chk("reset.mt_write_reg",   32'(mt_write_reg),   32'd0);
        chk("reset.mt_write_data",  mt_write_data,       32'd0);
        chk("reset.init_done",      32'(init_done),      32'd0);
        chk("reset.dispatch_ready", 32'(dispatch_ready), 32'd0);
        chk("reset.commit_ready",   32'(commit_ready),   32'd0);
        reset = 1'b0;

        run_sweep(31);
        for (int i = 0; i <= 14; i++) step(tbl[i], $sformatf("vec%0d", i));
        run_sweep(31);
        for (int i = 15; i <= 16; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Recover in RUN, then async reset once the sweep reaches entry 17.
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), "rec2");
        run_sweep(16);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.mt_reg_write", 32'(mt_reg_write), 32'd0);
        chk("midreset.init_done",    32'(init_done),    32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_sweep(31);
        step(tbl[15], "post_reset_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
